// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: shared constants and types for the SPI flash responder.
//   - Opcodes understood by the responder (READ, FAST_READ, RDID).
//   - Frame geometry: 24 address bits, 8 dummy clocks for FAST_READ.
//   - Responder state encoding and a small JEDEC-ID index helper.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_RDID      = 8'h9F;

  localparam int ADDR_BITS  = 24;
  localparam int DUMMY_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_DATA   = 3'd4,
    ST_ID     = 3'd5,
    ST_IGNORE = 3'd6
  } state_e;

  // JEDEC ID is three bytes long and repeats: 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] id_next(input logic [1:0] idx);
    case (idx)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: two-flop synchroniser for an asynchronous SPI pin plus
// rise/fall pulses derived from the synchronised value.
// Ports:
//   clk_in  - system clock
//   rst_in  - synchronous reset, active high (chain clears to 0)
//   d_in    - asynchronous input pin
//   rise_o  - one-cycle pulse when the synchronised value goes 0 -> 1
//   fall_o  - one-cycle pulse when the synchronised value goes 1 -> 0
// The chain resets to 0, so a pin that is high after reset produces a rise;
// the responder uses that rise as its "ncs seen high" arming event.
module spi_edge_sync (
  input  logic clk_in,
  input  logic rst_in,
  input  logic d_in,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Next values of the synchroniser chain and the edge-history flop.
  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchroniser and history registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 serial NOR flash emulator, oversampled by
// clk_in (>= 8x the SPI clock). Serves READ (0x03) and RDID (0x9F) out of an
// internal 2^ADDR_W byte array that is preloaded through the load_* port.
// Optional build macro SPI_FLASH_FAST_READ_EN adds FAST_READ (0x0B: address,
// 8 dummy clocks, data); without it 0x0B is ignored like any unknown opcode.
// Ports:
//   clk_in, rst_in      - system clock, synchronous active-high reset
//   ncs, dclk, mosi     - SPI pins, asynchronous to clk_in
//   miso, miso_oe       - SPI data out and its drive enable
//   busy                - transaction in progress
//   load_valid/addr/data, load_ready - preload write port (ready = !busy)
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int         ADDR_W   = 12,
  parameter logic [7:0] MANUF_ID = 8'hEF,
  parameter logic [7:0] MEM_TYPE = 8'h40,
  parameter logic [7:0] CAPACITY = 8'h18
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              ncs,
  input  logic              dclk,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              busy,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              load_ready
);

  localparam logic [4:0] ADDR_LAST = 5'(ADDR_BITS - 1);

  logic ncs_rise_s, ncs_fall_s, dclk_rise_s, dclk_fall_s;
  logic mosi_meta_q, mosi_meta_d, mosi_s, mosi_sync_d;

  spi_edge_sync u_ncs_sync (
    .clk_in (clk_in), .rst_in (rst_in), .d_in (ncs),
    .rise_o (ncs_rise_s), .fall_o (ncs_fall_s)
  );

  spi_edge_sync u_dclk_sync (
    .clk_in (clk_in), .rst_in (rst_in), .d_in (dclk),
    .rise_o (dclk_rise_s), .fall_o (dclk_fall_s)
  );

  state_e            state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        shift_q, shift_d;
  logic [1:0]        id_idx_q, id_idx_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic              busy_q, busy_d;
  logic              armed_q, armed_d;
  logic [7:0]        rd_data_q;
  logic [7:0]        id_byte_s, out_byte_s, opcode_s;
  logic [7:0]        mem_q [0:(1<<ADDR_W)-1];
`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_BITS - 1);
  logic              fast_q, fast_d;
`endif

  // mosi only needs to be stable at dclk rises, so no edge detection.
  always_comb begin
    mosi_meta_d = mosi;
    mosi_sync_d = mosi_meta_q;
  end

  // mosi synchroniser; aligned with the dclk chain so a detected rise sees
  // the bit that was presented before it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mosi_meta_q <= 1'b0;
      mosi_s      <= 1'b0;
    end else begin
      mosi_meta_q <= mosi_meta_d;
      mosi_s      <= mosi_sync_d;
    end
  end

  // JEDEC ID byte selected by the rolling index.
  always_comb begin
    case (id_idx_q)
      2'd0:    id_byte_s = MANUF_ID;
      2'd1:    id_byte_s = MEM_TYPE;
      default: id_byte_s = CAPACITY;
    endcase
  end

  // Byte array: preload writes only while idle; the read port follows
  // addr_q every cycle so the next byte is fetched long before its first fall.
  always_ff @(posedge clk_in) begin
    if (load_valid && !busy_q) begin
      mem_q[load_addr] <= load_data;
    end
    rd_data_q <= mem_q[addr_q];
  end

  // Protocol FSM next-state and output logic.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    id_idx_d   = id_idx_q;
    miso_d     = miso_q;
    armed_d    = armed_q | ncs_rise_s;
    opcode_s   = {cmd_q, mosi_s};
    out_byte_s = (state_q == ST_DATA) ? rd_data_q : id_byte_s;
`ifdef SPI_FLASH_FAST_READ_EN
    fast_d     = fast_q;
`endif

    if (ncs_rise_s) begin
      // End of frame from any state; partial bytes are simply dropped.
      state_d   = ST_IDLE;
      miso_d    = 1'b0;
      bit_cnt_d = 5'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ncs_fall_s && armed_q) begin
            state_d   = ST_CMD;
            bit_cnt_d = 5'd0;
            miso_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CMD: begin
          if (dclk_rise_s) begin
            cmd_d = opcode_s[6:0];
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = 5'd0;
`ifdef SPI_FLASH_FAST_READ_EN
              fast_d = (opcode_s == OP_FAST_READ);
`endif
              case (opcode_s)
                OP_READ: state_d = ST_ADDR;
                OP_RDID: begin
                  state_d  = ST_ID;
                  id_idx_d = 2'd0;
                end
`ifdef SPI_FLASH_FAST_READ_EN
                OP_FAST_READ: state_d = ST_ADDR;
`endif
                default: state_d = ST_IGNORE;
              endcase
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end else begin
            state_d = ST_CMD;
          end
        end
        ST_ADDR: begin
          if (dclk_rise_s) begin
            // Shifting through an ADDR_W register drops the unused high bits.
            addr_d = {addr_q[ADDR_W-2:0], mosi_s};
            if (bit_cnt_q == ADDR_LAST) begin
              bit_cnt_d = 5'd0;
`ifdef SPI_FLASH_FAST_READ_EN
              state_d = fast_q ? ST_DUMMY : ST_DATA;
`else
              state_d = ST_DATA;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end else begin
            state_d = ST_ADDR;
          end
        end
`ifdef SPI_FLASH_FAST_READ_EN
        ST_DUMMY: begin
          if (dclk_rise_s) begin
            if (bit_cnt_q == DUMMY_LAST) begin
              bit_cnt_d = 5'd0;
              state_d   = ST_DATA;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end else begin
            state_d = ST_DUMMY;
          end
        end
`endif
        ST_DATA, ST_ID: begin
          if (dclk_fall_s) begin
            // Bit 0 of a byte loads the whole byte; later falls shift it out.
            if (bit_cnt_q == 5'd0) begin
              {miso_d, shift_d} = {out_byte_s, 1'b0};
            end else begin
              {miso_d, shift_d} = {shift_q, 1'b0};
            end
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = 5'd0;
              if (state_q == ST_DATA) begin
                addr_d = addr_q + ADDR_W'(1);
              end else begin
                id_idx_d = id_next(id_idx_q);
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_IGNORE: state_d = ST_IGNORE;
        default:   state_d = ST_IGNORE;
      endcase
    end

    busy_d    = (state_d != ST_IDLE);
    miso_oe_d = (state_d == ST_DATA) || (state_d == ST_ID);
  end

  // Protocol state registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 5'd0;
      cmd_q     <= 7'd0;
      addr_q    <= '0;
      shift_q   <= 8'd0;
      id_idx_q  <= 2'd0;
      miso_q    <= 1'b0;
      miso_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      armed_q   <= 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
      fast_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      shift_q   <= shift_d;
      id_idx_q  <= id_idx_d;
      miso_q    <= miso_d;
      miso_oe_q <= miso_oe_d;
      busy_q    <= busy_d;
      armed_q   <= armed_d;
`ifdef SPI_FLASH_FAST_READ_EN
      fast_q    <= fast_d;
`endif
    end
  end

  assign miso       = miso_q;
  assign miso_oe    = miso_oe_q;
  assign busy       = busy_q;
  assign load_ready = ~busy_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Testbench for spi_flash_responder: a table of directed transactions, hand
// sequences for abort/reset/busy-preload, and randomized READ/RDID traffic
// checked against a byte-array reference of the flash contents.
module tb_spi_flash_responder;

  localparam int HALF = 6;  // dclk half period in clk_in cycles

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        ncs = 1'b1, dclk = 1'b0, mosi = 1'b0;
  logic        miso, miso_oe, busy, load_ready;
  logic        load_valid = 1'b0;
  logic [11:0] load_addr = 12'd0;
  logic [7:0]  load_data = 8'd0;

  int checks = 0;
  int failures = 0;

  logic [7:0] ref_mem [4096];
  logic [7:0] id_tab [3];

  spi_flash_responder dut (
    .clk_in (clk_in), .rst_in (rst_in), .ncs (ncs), .dclk (dclk), .mosi (mosi),
    .miso (miso), .miso_oe (miso_oe), .busy (busy),
    .load_valid (load_valid), .load_addr (load_addr), .load_data (load_data),
    .load_ready (load_ready)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  typedef struct {
    logic        ld_en;
    logic [11:0] ld_addr;
    logic [7:0]  ld_data;
    logic [7:0]  op;
    logic [23:0] addr;
    int          n;
    logic [31:0] exp;
    logic        exp_oe;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [11:0] a, input logic [7:0] d, input logic upd);
    @(negedge clk_in);
    load_valid = 1'b1; load_addr = a; load_data = d;
    @(negedge clk_in);
    load_valid = 1'b0;
    if (upd) ref_mem[a] = d;
  endtask

  task automatic spi_bit(input logic b, output logic r, output logic oe);
    mosi = b;
    repeat (HALF) @(negedge clk_in);
    r = miso; oe = miso_oe;
    dclk = 1'b1;
    repeat (HALF) @(negedge clk_in);
    dclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx,
                          output logic oe_any, output logic oe_all);
    logic r, o;
    oe_any = 1'b0; oe_all = 1'b1; rx = 8'd0;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r, o);
      rx[i] = r; oe_any |= o; oe_all &= o;
    end
  endtask

  task automatic run_txn(input logic [7:0] op, input logic [23:0] addr, input int n,
                         output logic [31:0] data, output logic pre_oe,
                         output logic oe_any, output logic oe_all);
    logic [7:0] rx;
    logic a, l;
    data = 32'd0; pre_oe = 1'b0; oe_any = 1'b0; oe_all = 1'b1;
    ncs = 1'b0;
    repeat (4) @(negedge clk_in);
    spi_byte(op, rx, a, l); pre_oe |= a;
    if (op != 8'h9F) begin
      for (int k = 0; k < 3; k++) begin
        spi_byte(addr[23-8*k -: 8], rx, a, l); pre_oe |= a;
      end
    end
    if (op == 8'h0B) begin
      spi_byte(8'h00, rx, a, l); pre_oe |= a;
    end
    for (int k = 0; k < n; k++) begin
      spi_byte(8'h00, rx, a, l);
      data = {data[23:0], rx}; oe_any |= a; oe_all &= l;
    end
    ncs = 1'b1;
    repeat (8) @(negedge clk_in);
  endtask

  initial begin
    vec_t vecs [5];
    logic [31:0] data, exp;
    logic pre_oe, oe_any, oe_all, a, l, seen;
    logic [7:0] rx;
    logic r, o;
    int base, start, n;

    id_tab[0] = 8'hEF; id_tab[1] = 8'h40; id_tab[2] = 8'h18;

    vecs[0] = '{1'b0, 12'h000, 8'h00, 8'h03, 24'h000001, 3, 32'h00223344, 1'b1};
    vecs[1] = '{1'b1, 12'h000, 8'h5A, 8'h03, 24'h000FFF, 2, 32'h0000A55A, 1'b1};
    vecs[2] = '{1'b1, 12'h000, 8'h11, 8'h9F, 24'h000000, 4, 32'hEF4018EF, 1'b1};
`ifdef SPI_FLASH_FAST_READ_EN
    vecs[3] = '{1'b0, 12'h000, 8'h00, 8'h0B, 24'h000000, 1, 32'h00000011, 1'b1};
`else
    vecs[3] = '{1'b0, 12'h000, 8'h00, 8'h0B, 24'h000000, 1, 32'h00000000, 1'b0};
`endif
    vecs[4] = '{1'b0, 12'h000, 8'h00, 8'h05, 24'h000010, 2, 32'h00000000, 1'b0};

    // Reset state
    repeat (4) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("reset_miso", {31'd0, miso}, 32'd0);
    check("reset_oe", {31'd0, miso_oe}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_load_ready", {31'd0, load_ready}, 32'd1);
    repeat (6) @(negedge clk_in);

    do_load(12'h000, 8'h11, 1'b1);
    do_load(12'h001, 8'h22, 1'b1);
    do_load(12'h002, 8'h33, 1'b1);
    do_load(12'h003, 8'h44, 1'b1);
    do_load(12'hFFF, 8'hA5, 1'b1);

    // Directed table
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].ld_en) do_load(vecs[v].ld_addr, vecs[v].ld_data, 1'b1);
      run_txn(vecs[v].op, vecs[v].addr, vecs[v].n, data, pre_oe, oe_any, oe_all);
      check($sformatf("vec%0d_data", v), data, vecs[v].exp);
      check($sformatf("vec%0d_oe", v), {30'd0, oe_any, oe_all},
            {30'd0, vecs[v].exp_oe, vecs[v].exp_oe});
      check($sformatf("vec%0d_pre_oe", v), {31'd0, pre_oe}, 32'd0);
    end

    // Abort after 5 bits of the second data byte, then a fresh READ
    ncs = 1'b0;
    repeat (4) @(negedge clk_in);
    spi_byte(8'h03, rx, a, l);
    spi_byte(8'h00, rx, a, l);
    spi_byte(8'h00, rx, a, l);
    spi_byte(8'h01, rx, a, l);
    spi_byte(8'h00, rx, a, l);
    check("abort_first_byte", {24'd0, rx}, 32'h22);
    for (int i = 0; i < 5; i++) spi_bit(1'b0, r, o);
    ncs = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      if (!busy && !miso_oe && !seen) seen = 1'b1;
    end
    check("abort_idle_within_4", {31'd0, seen}, 32'd1);
    repeat (6) @(negedge clk_in);
    run_txn(8'h03, 24'h000002, 1, data, pre_oe, oe_any, oe_all);
    check("after_abort_data", data, 32'h33);

    // Reset in the middle of DATA with ncs held low
    ncs = 1'b0;
    repeat (4) @(negedge clk_in);
    spi_byte(8'h03, rx, a, l);
    for (int k = 0; k < 3; k++) spi_byte(8'h00, rx, a, l);
    spi_byte(8'h00, rx, a, l);
    check("pre_reset_byte", {24'd0, rx}, 32'h11);
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    spi_byte(8'h03, rx, oe_any, l);
    spi_byte(8'h00, rx, a, l);
    oe_any |= a;
    check("post_reset_oe", {31'd0, oe_any}, 32'd0);
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    check("post_reset_miso", {24'd0, rx}, 32'd0);
    ncs = 1'b1;
    repeat (8) @(negedge clk_in);

    // Preload attempt while busy must not land
    ncs = 1'b0;
    repeat (4) @(negedge clk_in);
    check("busy_in_frame", {30'd0, busy, load_ready}, 32'b10);
    do_load(12'h000, 8'hEE, 1'b0);
    spi_byte(8'h03, rx, a, l);
    for (int k = 0; k < 3; k++) spi_byte(8'h00, rx, a, l);
    spi_byte(8'h00, rx, a, l);
    check("busy_load_ignored", {24'd0, rx}, 32'h11);
    ncs = 1'b1;
    repeat (8) @(negedge clk_in);

    // Randomized traffic against the reference array
    for (int it = 0; it < 12; it++) begin
      base = $urandom_range(0, 4095);
      for (int j = 0; j < 8; j++) do_load(12'((base + j) % 4096), 8'($urandom), 1'b1);
      n = $urandom_range(1, 4);
      exp = 32'd0;
      if (it % 4 == 3) begin
        for (int k = 0; k < n; k++) exp = {exp[23:0], id_tab[k % 3]};
        run_txn(8'h9F, 24'd0, n, data, pre_oe, oe_any, oe_all);
      end else begin
        start = (base + $urandom_range(0, 3)) % 4096;
        for (int k = 0; k < n; k++) exp = {exp[23:0], ref_mem[(start + k) % 4096]};
        run_txn(8'h03, {12'($urandom), 12'(start)}, n, data, pre_oe, oe_any, oe_all);
      end
      check($sformatf("rand%0d_data", it), data, exp);
      check($sformatf("rand%0d_oe", it), {29'd0, pre_oe, oe_any, oe_all}, 32'b011);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
